// File: rtl/mc_sequencer_pkg.sv
// rtl/mc_sequencer_pkg.sv - shared types and encodings for the multi-cycle sequencer
//
// Purpose: state enum, instruction-class constants, pc_src encodings,
//          load/store subcodes, branch condition selectors and the
//          one-hot instruction class produced by mc_decode.
// Ports:   none (package).
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Opcode class prefixes, compared against progressively wider ir slices
  localparam logic [1:0]  OP_R      = 2'b00;     // ir[18:17]
  localparam logic [1:0]  OP_IMM    = 2'b01;     // ir[18:17]
  localparam logic [2:0]  OP_MEM    = 3'b100;    // ir[18:16]
  localparam logic [2:0]  OP_BR     = 3'b101;    // ir[18:16]
  localparam logic [2:0]  OP_SHIFT  = 3'b110;    // ir[18:16]
  localparam logic [3:0]  OP_JMP    = 4'b1110;   // ir[18:15]
  localparam logic [5:0]  OP_RET    = 6'b111100; // ir[18:13]
  localparam logic [18:0] HALT_WORD = 19'h7FFFF;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_STACK  = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  localparam logic [1:0] MEM_LOAD  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;

  localparam logic [1:0] BR_Z  = 2'b00;
  localparam logic [1:0] BR_NZ = 2'b01;
  localparam logic [1:0] BR_C  = 2'b10;
  localparam logic [1:0] BR_NC = 2'b11;

  // Exactly one member is set for any ir value
  typedef struct packed {
    logic r;
    logic imm;
    logic shift;
    logic load;
    logic store;
    logic br;
    logic jmp;
    logic ret;
    logic halt;
    logic nop;
  } iclass_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - shared single-port memory request/ack bundle
//
// Purpose: groups the sequencer-to-memory handshake.
// Signals: mem_req        request (sequencer -> memory)
//          mem_read_write 0=read, 1=write
//          mem_addr_sel   0=PC, 1=ALU result
//          mem_ack        completion pulse (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
interface mc_sequencer_if;
  logic mem_req;
  logic mem_read_write;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_read_write, output mem_addr_sel,
                  input  mem_ack);
  modport slave  (input  mem_req, input  mem_read_write, input  mem_addr_sel,
                  output mem_ack);
endinterface

// File: rtl/mc_sequencer_decode.sv
// rtl/mc_sequencer_decode.sv - combinational instruction classifier
//
// Purpose: classifies ir into a one-hot class and extracts the ALU op,
//          shift op, branch condition selector and jsb bit.
// Ports:   i_ir      instruction register
//          o_cls     one-hot instruction class
//          o_acode   ALU op ir[16:14]
//          o_scode   shift op ir[15:14]
//          o_br_cond branch condition selector ir[15:14]
//          o_jsb     jump-to-subroutine bit ir[14]
module mc_decode
  import ctrl_pkg::*;
(
  input  logic [18:0] i_ir,
  output iclass_t     o_cls,
  output logic [2:0]  o_acode,
  output logic [1:0]  o_scode,
  output logic [1:0]  o_br_cond,
  output logic        o_jsb
);

  assign o_acode   = i_ir[16:14];
  assign o_scode   = i_ir[15:14];
  assign o_br_cond = i_ir[15:14];
  assign o_jsb     = i_ir[14];

  // Priority order matters: the halt word lies inside the 1111xx space,
  // so it is matched before the wider prefixes.
  always_comb begin
    o_cls = '0;
    if (i_ir == HALT_WORD) begin
      o_cls.halt = 1'b1;
    end else if (i_ir[18:17] == OP_R) begin
      o_cls.r = 1'b1;
    end else if (i_ir[18:17] == OP_IMM) begin
      o_cls.imm = 1'b1;
    end else if (i_ir[18:16] == OP_SHIFT) begin
      o_cls.shift = 1'b1;
    end else if (i_ir[18:16] == OP_MEM) begin
      if (i_ir[15:14] == MEM_LOAD) begin
        o_cls.load = 1'b1;
      end else if (i_ir[15:14] == MEM_STORE) begin
        o_cls.store = 1'b1;
      end else begin
        o_cls.nop = 1'b1;
      end
    end else if (i_ir[18:16] == OP_BR) begin
      o_cls.br = 1'b1;
    end else if (i_ir[18:15] == OP_JMP) begin
      o_cls.jmp = 1'b1;
    end else if (i_ir[18:13] == OP_RET) begin
      o_cls.ret = 1'b1;
    end else begin
      o_cls.nop = 1'b1;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle control sequencer over a shared memory port
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB/HALT, arbitrating fetch and
//          load/store onto one memory port and emitting datapath controls.
// Ports:   clk, rst             clock, synchronous active-high reset
//          i_ir                 instruction register
//          i_zero, i_carry      registered Z / C flags (sampled in EXEC)
//          mem                  memory handshake (master side)
//          o_ir_write           load IR from memory data
//          o_pc_write, o_pc_src PC load strobe and source select
//          o_reg2_read_source, o_alu_src, o_is_shift, o_mem_or_alu,
//          o_reg_write_signal, o_update_z_c, o_stack_push, o_stack_pop,
//          o_acode, o_scode     datapath controls
//          o_halted             high in HALT
module mc_sequencer
  import ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [18:0]           i_ir,
  input  logic                  i_zero,
  input  logic                  i_carry,
  mc_sequencer_if.master        mem,
  output logic                  o_ir_write,
  output logic                  o_pc_write,
  output logic [1:0]            o_pc_src,
  output logic                  o_reg2_read_source,
  output logic                  o_alu_src,
  output logic                  o_is_shift,
  output logic                  o_mem_or_alu,
  output logic                  o_reg_write_signal,
  output logic                  o_update_z_c,
  output logic                  o_stack_push,
  output logic                  o_stack_pop,
  output logic [2:0]            o_acode,
  output logic [1:0]            o_scode,
  output logic                  o_halted
);

  state_t      r_state;
  state_t      w_next;
  iclass_t     w_cls;
  logic [2:0]  w_acode;
  logic [1:0]  w_scode;
  logic [1:0]  w_br_cond;
  logic        w_jsb;
  logic        w_br_taken;

  mc_decode u_decode (
    .i_ir      (i_ir),
    .o_cls     (w_cls),
    .o_acode   (w_acode),
    .o_scode   (w_scode),
    .o_br_cond (w_br_cond),
    .o_jsb     (w_jsb)
  );

  always_comb begin
    w_br_taken = 1'b0;
    case (w_br_cond)
      BR_Z:    w_br_taken = i_zero;
      BR_NZ:   w_br_taken = !i_zero;
      BR_C:    w_br_taken = i_carry;
      BR_NC:   w_br_taken = !i_carry;
      default: w_br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next             = r_state;
    mem.mem_req        = 1'b0;
    mem.mem_read_write = 1'b0;
    mem.mem_addr_sel   = 1'b0;
    o_ir_write         = 1'b0;
    o_pc_write         = 1'b0;
    o_pc_src           = PC_INC;
    o_reg2_read_source = 1'b0;
    o_alu_src          = 1'b0;
    o_is_shift         = 1'b0;
    o_mem_or_alu       = 1'b0;
    o_reg_write_signal = 1'b0;
    o_update_z_c       = 1'b0;
    o_stack_push       = 1'b0;
    o_stack_pop        = 1'b0;
    o_acode            = 3'd0;
    o_scode            = 2'd0;
    o_halted           = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          o_pc_src   = PC_INC;
          w_next     = S_DECODE;
        end
      end

      S_DECODE: begin
        w_next = w_cls.halt ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        w_next = S_FETCH;
        if (w_cls.r || w_cls.imm) begin
          o_acode      = w_acode;
          o_alu_src    = w_cls.imm;
          o_update_z_c = 1'b1;
          w_next       = S_WB;
        end else if (w_cls.shift) begin
          o_is_shift   = 1'b1;
          o_scode      = w_scode;
          o_update_z_c = 1'b1;
          w_next       = S_WB;
        end else if (w_cls.load || w_cls.store) begin
          o_reg2_read_source = 1'b1;
          o_alu_src          = 1'b1;
          w_next             = S_MEM;
        end else if (w_cls.br) begin
          if (w_br_taken) begin
            o_pc_write = 1'b1;
            o_pc_src   = PC_BRANCH;
          end
        end else if (w_cls.jmp) begin
          o_pc_write   = 1'b1;
          o_pc_src     = PC_JUMP;
          o_stack_push = w_jsb;
        end else if (w_cls.ret) begin
          o_pc_write  = 1'b1;
          o_pc_src    = PC_STACK;
          o_stack_pop = 1'b1;
        end else if (w_cls.nop || w_cls.halt) begin
          // Halt cannot reach EXEC (DECODE diverts it); both retire as NOP
          w_next = S_FETCH;
        end
      end

      S_MEM: begin
        // Address and direction stay stable for the whole wait
        mem.mem_req        = 1'b1;
        mem.mem_addr_sel   = 1'b1;
        mem.mem_read_write = w_cls.store;
        o_alu_src          = 1'b1;
        o_reg2_read_source = 1'b1;
        if (mem.mem_ack) begin
          w_next = w_cls.load ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        // ALU/shifter selects are held from EXEC so the result bus stays valid
        o_reg_write_signal = 1'b1;
        o_mem_or_alu       = !w_cls.load;
        if (w_cls.r || w_cls.imm) begin
          o_acode   = w_acode;
          o_alu_src = w_cls.imm;
        end
        if (w_cls.shift) begin
          o_is_shift = 1'b1;
          o_scode    = w_scode;
        end
        if (w_cls.load) begin
          o_alu_src = 1'b1;
        end
        w_next = S_FETCH;
      end

      S_HALT: begin
        o_halted = 1'b1;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase

    // Reset silences every output and discards any in-flight ack
    if (rst) begin
      w_next             = S_FETCH;
      mem.mem_req        = 1'b0;
      mem.mem_read_write = 1'b0;
      mem.mem_addr_sel   = 1'b0;
      o_ir_write         = 1'b0;
      o_pc_write         = 1'b0;
      o_pc_src           = PC_INC;
      o_reg2_read_source = 1'b0;
      o_alu_src          = 1'b0;
      o_is_shift         = 1'b0;
      o_mem_or_alu       = 1'b0;
      o_reg_write_signal = 1'b0;
      o_update_z_c       = 1'b0;
      o_stack_push       = 1'b0;
      o_stack_pop        = 1'b0;
      o_acode            = 3'd0;
      o_scode            = 2'd0;
      o_halted           = 1'b0;
    end
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the 19-bit-instruction processor. It lets fetch and load/store share one single-port memory through a req/ack handshake. It owns the instruction register load and PC update, and emits the same datapath controls as the single-cycle controller, each in the correct cycle. It sits between the instruction register, flag register, shared memory port and the register file/ALU/shifter/return stack.

## Interface
No parameters; widths are fixed by the ISA.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ir  in  19  instruction register contents (valid from DECODE onward)
- zero  in  1  registered Z flag
- carry  in  1  registered C flag
- mem_ack  in  1  memory completion pulse; honoured only while mem_req=1
- mem_req  out  1  memory access request
- mem_read_write  out  1  0=read, 1=write
- mem_addr_sel  out  1  0=PC, 1=ALU result
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC from pc_src mux
- pc_src  out  2  00=PC+1, 01=jump target, 10=stack top, 11=branch target
- reg2_read_source, alu_src, is_shift, mem_or_alu, reg_write_signal, update_z_c, stack_push, stack_pop  out  1 each  datapath controls, same meaning as in the single-cycle controller
- acode  out  3  ALU op; scode  out  2  shift op
- halted  out  1  high in HALT state

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_addr_sel=0, read.
  - On mem_ack: ir_write=1, pc_write=1 with pc_src=00, go to DECODE. Otherwise stay.
- DECODE: one cycle with no side effects, then go to EXEC.
  - Exception: ir=19'h7FFFF goes to HALT.
- EXEC, by ir class:
  - ir[18:17]=00 (R): acode=ir[16:14], alu_src=0, update_z_c=1, go to WB.
  - ir[18:17]=01 (immediate): as R, but alu_src=1.
  - ir[18:16]=110 (shift): is_shift=1, scode=ir[15:14], update_z_c=1, go to WB.
  - ir[18:16]=100 with ir[15:14]=00 (load) or 01 (store): reg2_read_source=1, alu_src=1, go to MEM.
  - ir[18:16]=100 with ir[15:14]=1x: NOP, go to FETCH.
  - ir[18:16]=101 (branch): the condition is selected by ir[15:14]:
    - 00: zero=1
    - 01: zero=0
    - 10: carry=1
    - 11: carry=0
    - If true: pc_write=1, pc_src=11. Go to FETCH.
  - ir[18:15]=1110 (jmp/jsb): pc_write=1, pc_src=01, stack_push=ir[14], go to FETCH.
  - ir[18:13]=111100 (ret): pc_write=1, pc_src=10, stack_pop=1, go to FETCH.
  - Any other encoding: NOP, go to FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, alu_src=1, reg2_read_source=1, mem_read_write=1 for store.
  - Held until mem_ack.
  - On ack: load goes to WB, store goes to FETCH.
- WB:
  - reg_write_signal=1, then go to FETCH.
  - mem_or_alu=1 for R, immediate and shift; mem_or_alu=0 for load.
  - acode, scode, alu_src and is_shift are held from EXEC.
- HALT: all controls 0, halted=1. Left only by rst.

## Timing
- Outputs are combinational from the state register and ir. All strobes (ir_write, pc_write, reg_write_signal, update_z_c, stack_push, stack_pop) are single-cycle.
- Reset:
  - While rst=1 every output is forced to 0, including mem_req.
  - State becomes FETCH at the edge where rst=1.
  - Reset mid-access abandons the access; a mem_ack arriving during or after reset is ignored.
- Handshake:
  - mem_req stays high and the address/direction stay stable until the mem_ack cycle.
  - mem_ack may arrive in the same cycle that mem_req rises (zero wait).
  - mem_ack while mem_req=0 is ignored.
- Cycle counts with zero-wait memory: R, immediate, shift = 4; load = 5; store = 4; branch, jmp, jsb, ret = 3.
- Each wait cycle extends FETCH or MEM by one.
- Flags are sampled in the EXEC cycle only. update_z_c in an R-type EXEC does not affect a branch that has already resolved.

## Structure
- Package ctrl_pkg holds:
  - the state enum;
  - opcode class constants (R, IMM, SHIFT, MEM, BR, JMP, RET, HALT word 19'h7FFFF);
  - pc_src encodings;
  - the load/store subcodes.
- Sub-module mc_decode is combinational. It classifies ir into a one-hot instruction class and extracts acode, scode, branch condition and the jsb bit. The sequencer FSM consumes the class.

## Test plan
- R add, ir=19'b00_000_..., ack same cycle → FETCH/DECODE/EXEC/WB in 4 cycles; update_z_c=1 in EXEC; reg_write_signal=1 with mem_or_alu=1 in WB; pc_write exactly once.
- Load with 2-cycle ack delay in MEM → mem_req=1 and mem_addr_sel=1 for 3 cycles; WB has mem_or_alu=0 and reg_write_signal=1; total 7 cycles.
- Store ir[15:14]=01 → mem_read_write=1 only in MEM; no reg_write_signal; returns to FETCH after ack.
- Branch ir[18:14]=10101 (bne) with zero=0 → pc_write=1, pc_src=11 in EXEC. Same instruction with zero=1 → pc_write=0.
- jsb ir[18:14]=11101 → stack_push=1, pc_src=01. ret ir[18:13]=111100 → stack_pop=1, pc_src=10. Both strobes last one cycle.
- rst asserted mid-MEM with mem_ack arriving next cycle → outputs 0, ack ignored, FETCH with mem_req=1 the cycle after rst drops. HALT word → halted=1, no further mem_req.
